// File: rtl/rx_frame_strip.sv
// rx_frame_strip: strips preamble/SFD from a byte PHY stream, flags frame good/bad; RX_CRC_CHECK_EN adds FCS residue check
module rx_frame_strip #(
  parameter int PREAMBLE_MIN = 3,
  parameter int MAX_FRAME    = 1522,
  parameter int MIN_FRAME    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phy_dv,
  input  logic        phy_err,
  input  logic [7:0]  phy_data,
  output logic        rx_enable,
  output logic [7:0]  data,
  output logic [10:0] byte_count,
  output logic        frame_done,
  output logic        frame_good,
  output logic        crc_ok
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;
  localparam logic [2:0]  P_MIN = 3'(PREAMBLE_MIN);
  localparam logic [10:0] F_MIN = 11'(MIN_FRAME);
  localparam logic [10:0] F_MAX = 11'(MAX_FRAME);
  state_t     state;
  logic [2:0] pcnt;
  logic       crc_res;
  logic       len_ok;
  logic       sfd;
  logic       take;
  assign len_ok = byte_count >= F_MIN && byte_count <= F_MAX;
  assign sfd    = state == PREAMBLE && phy_dv && !phy_err && phy_data == 8'hD5 && pcnt >= P_MIN;
  assign take   = state == PAYLOAD && phy_dv && !phy_err && byte_count != F_MAX;
`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc, crc_next;
  always_comb begin
    crc_next = crc ^ {24'd0, phy_data};
    for (int i = 0; i < 8; i++) crc_next = crc_next[0] ? (crc_next >> 1) ^ 32'hEDB88320 : crc_next >> 1;
  end
  assign crc_res = crc == 32'hDEBB20E3;
  always_ff @(posedge clock)
    if (reset || sfd) crc <= 32'hFFFFFFFF;
    else if (take) crc <= crc_next;
  always_ff @(posedge clock)
    if (reset || sfd) crc_ok <= 1'b0;
    else if (state == PAYLOAD && !take) crc_ok <= crc_res;
`else
  assign crc_res = 1'b1;
  assign crc_ok  = 1'b1;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pcnt       <= 3'd0;
      rx_enable  <= 1'b0;
      data       <= 8'd0;
      byte_count <= 11'd0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (phy_dv && phy_data == 8'h55) begin
            state <= PREAMBLE;
            pcnt  <= 3'd1;
          end
        PREAMBLE:
          if (!phy_dv) state <= IDLE;
          else if (phy_err) state <= DROP;
          else if (phy_data == 8'h55) pcnt <= pcnt == 3'd7 ? pcnt : pcnt + 3'd1;
          else if (sfd) begin
            state      <= PAYLOAD;
            byte_count <= 11'd0;
            frame_good <= 1'b0;
          end else state <= DROP;
        PAYLOAD:
          if (!phy_dv) begin
            state      <= IDLE;
            rx_enable  <= 1'b0;
            frame_done <= 1'b1;
            frame_good <= len_ok & crc_res;
          end else if (!take) begin
            // error or overlength: abort now, remaining bytes swallowed in DROP
            state      <= DROP;
            rx_enable  <= 1'b0;
            frame_done <= 1'b1;
            frame_good <= 1'b0;
          end else begin
            data       <= phy_data;
            rx_enable  <= 1'b1;
            byte_count <= byte_count + 11'd1;
          end
        default:
          if (!phy_dv) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_strip.sv
// tb_rx_frame_strip: directed frames with a queued scoreboard checked by a negedge monitor
module tb_rx_frame_strip;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b1, phy_dv = 1'b0, phy_err = 1'b0;
  logic [7:0]  phy_data = 8'd0;
  logic        rx_enable, frame_done, frame_good, crc_ok;
  logic [7:0]  data;
  logic [10:0] byte_count;
  int total = 0, bad = 0;
  typedef struct packed {logic good; logic [10:0] cnt; logic [1:0] crc;} frm_t;
  logic [7:0] exp_data[$];
  frm_t       exp_frm[$];
  logic [7:0] pay[$];

  rx_frame_strip dut (
    .clock(clock), .reset(reset), .phy_dv(phy_dv), .phy_err(phy_err), .phy_data(phy_data),
    .rx_enable(rx_enable), .data(data), .byte_count(byte_count),
    .frame_done(frame_done), .frame_good(frame_good), .crc_ok(crc_ok)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (rx_enable === 1'b1) begin
      if (exp_data.size() == 0) chk("extra data byte", exp_data.size(), 1);
      else chk("data", data, exp_data.pop_front());
    end
    if (frame_done === 1'b1) begin
      if (exp_frm.size() == 0) chk("unexpected frame_done", exp_frm.size(), 1);
      else begin
        frm_t f;
        f = exp_frm.pop_front();
        chk("frame_good", frame_good, f.good);
        chk("byte_count", byte_count, f.cnt);
        if (f.crc != 2'd2) chk("crc_ok", crc_ok, f.crc);
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    c = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay[i]) c = crc_upd(c, pay[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) pay.push_back(c[8*i +: 8]);
  endtask

  task automatic mk(input int n, input int seed);
    pay.delete();
    for (int i = 0; i < n - 4; i++) pay.push_back(8'(seed + i * 13));
    add_fcs();
  endtask

  task automatic mk_arp();
    logic [7:0] hdr[42] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff,
                            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h06,
                            8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hc0, 8'ha8, 8'h01, 8'h01,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h02};
    pay.delete();
    foreach (hdr[i]) pay.push_back(hdr[i]);
    for (int i = 0; i < 18; i++) pay.push_back(8'h00);
    add_fcs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      phy_dv = 1'b0; phy_err = 1'b0; phy_data = 8'h00;
    end
  endtask

  task automatic preamble(input int npre);
    for (int i = 0; i < npre; i++) begin
      @(negedge clock);
      phy_dv = 1'b1; phy_err = 1'b0; phy_data = 8'h55;
    end
    @(negedge clock);
    phy_data = 8'hD5;
  endtask

  // sends pay[] then one phy_dv-low clock; frame expectation queued up front
  task automatic send(input int npre, input int err_at, input bit good, input int cnt, input logic [1:0] crc_e);
    bit acc, live;
    acc  = npre >= 3;
    live = acc;
    if (acc) exp_frm.push_back('{good, 11'(cnt), crc_e});
    preamble(npre);
    for (int i = 0; i < pay.size(); i++) begin
      @(negedge clock);
      if (acc && i == 0) chk("enable before first byte", rx_enable, 0);
      if (acc && i == 1) chk("latency first byte", {rx_enable, data}, {1'b1, pay[0]});
      if (i == err_at || i >= 1522) live = 0;
      if (live) exp_data.push_back(pay[i]);
      phy_err  = i == err_at;
      phy_data = pay[i];
    end
    idle(1);
  endtask

  initial begin
    idle(3);
    chk("reset rx_enable", rx_enable, 0);
    chk("reset data", data, 0);
    chk("reset byte_count", byte_count, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_good", frame_good, 0);
    chk("reset crc_ok", crc_ok, CRC_EN ? 0 : 1);
    reset = 1'b0;
    idle(2);
    mk_arp();
    send(7, -1, 1'b1, 64, 2'd1);
    pay[60] = pay[60] ^ 8'h01;
    send(7, -1, !CRC_EN, 64, CRC_EN ? 2'd0 : 2'd1);
    mk_arp();
    send(2, -1, 1'b0, 0, 2'd2);
    idle(2);
    send(3, -1, 1'b1, 64, 2'd1);
    mk(63, 5);
    send(7, -1, 1'b0, 63, 2'd1);
    mk(64, 9);
    send(7, 20, 1'b0, 20, 2'd2);
    idle(2);
    mk(1600, 3);
    send(7, -1, 1'b0, 1522, 2'd2);
    idle(2);
    mk(1522, 7);
    send(7, -1, 1'b1, 1522, 2'd1);
    mk(64, 11);
    send(7, -1, 1'b1, 64, 2'd1);
    mk(64, 17);
    preamble(7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      exp_data.push_back(pay[i]);
      phy_data = pay[i];
    end
    @(negedge clock);
    reset = 1'b1;
    phy_data = pay[10];
    @(negedge clock);
    chk("midreset rx_enable", rx_enable, 0);
    chk("midreset data", data, 0);
    chk("midreset byte_count", byte_count, 0);
    chk("midreset frame_done", frame_done, 0);
    chk("midreset frame_good", frame_good, 0);
    reset = 1'b0;
    for (int i = 11; i < 30; i++) begin
      phy_data = pay[i];
      @(negedge clock);
    end
    idle(3);
    mk(64, 23);
    send(7, -1, 1'b1, 64, 2'd1);
    idle(4);
    chk("data queue drained", exp_data.size(), 0);
    chk("frame queue drained", exp_frm.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
